// File: rtl/tm1638_link.sv
// TM1638 byte-level serial engine.
// Frames STB around one or more bytes, shifts write bytes out LSB first,
// releases DIO for the turnaround wait and clocks in READ_BYTES key-scan bytes.
// Requests use a valid/ready handshake. DIO is split into out/oe/in so the
// tristate buffer can live in the top-level IO cell.
module tm1638_link #(
  parameter int BIT_CYCLES  = 96,  // clk cycles per serial bit, even and >= 8
  parameter int STB_SETUP   = 12,  // STB low before the first CLK fall of a frame
  parameter int WAIT_CYCLES = 24,  // DIO released, CLK high, before the first read bit
  parameter int STB_GAP     = 12,  // STB high after a frame before o_ready returns
  parameter int READ_BYTES  = 4,   // bytes clocked in per read, 1..4
  parameter int KEY_ROW     = 0    // key-scan bit offset inside each byte, 0..2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_read,
  input  logic                    i_last,
  input  logic [7:0]              i_data,
  output logic                    o_rd_valid,
  output logic [8*READ_BYTES-1:0] o_rd_data,
  output logic [2*READ_BYTES-1:0] o_keys,
  output logic                    o_tm1638_clk,
  output logic                    o_tm1638_stb,
  output logic                    o_dio_out,
  output logic                    o_dio_oe,
  input  logic                    i_dio_in,
  output logic                    o_idle
);

  localparam int NB     = 8 * READ_BYTES;
  localparam int PW     = $clog2(BIT_CYCLES);
  localparam int BW     = $clog2(NB);
  localparam int CMAX_A = (STB_SETUP > WAIT_CYCLES) ? STB_SETUP : WAIT_CYCLES;
  localparam int CMAX   = (CMAX_A > STB_GAP) ? CMAX_A : STB_GAP;
  localparam int CW     = (CMAX < 2) ? 1 : $clog2(CMAX);

  localparam logic [PW-1:0] P_LAST       = PW'(BIT_CYCLES - 1);
  localparam logic [PW-1:0] P_HALF       = PW'(BIT_CYCLES / 2);
  localparam logic [PW-1:0] P_SAMPLE     = PW'((3 * BIT_CYCLES) / 4);
  localparam logic [BW-1:0] BIT_OUT_LAST = BW'(7);
  localparam logic [BW-1:0] BIT_IN_LAST  = BW'(NB - 1);
  localparam logic [CW-1:0] SETUP_LAST   = CW'(STB_SETUP - 1);
  localparam logic [CW-1:0] WAIT_LAST    = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(STB_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT_OUT,
    S_HOLD,
    S_TURN,
    S_SHIFT_IN,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;          // setup / turnaround / gap timer
  logic [PW-1:0]   p_q, p_d;              // phase inside the current bit
  logic [BW-1:0]   bit_q, bit_d;          // bit index inside the byte or read burst
  logic [7:0]      data_q, data_d;
  logic            read_q, read_d;
  logic            last_q, last_d;
  logic [NB-2:0]   rx_q, rx_d;            // bits received so far, newest at the top
  logic [NB-1:0]   rd_data_q, rd_data_d;
  logic [2*READ_BYTES-1:0] keys_q, keys_d;
  logic            rd_valid_q, rd_valid_d;
  logic            clk_q, clk_d;
  logic            stb_q, stb_d;
  logic            dio_q, dio_d;
  logic            oe_q, oe_d;
  logic            accept;

  assign o_ready = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign accept  = i_valid && o_ready;
  assign o_idle  = (state_q == S_IDLE) && !i_valid;

  assign o_rd_valid   = rd_valid_q;
  assign o_rd_data    = rd_data_q;
  assign o_keys       = keys_q;
  assign o_tm1638_clk = clk_q;
  assign o_tm1638_stb = stb_q;
  assign o_dio_out    = dio_q;
  assign o_dio_oe     = oe_q;

  // Key bits follow the byte that will be registered, so keys and rd_data
  // always update together and hold together.
  for (genvar gi = 0; gi < READ_BYTES; gi++) begin : g_keys
    assign keys_d[gi]              = rd_data_d[8*gi + KEY_ROW];
    assign keys_d[gi + READ_BYTES] = rd_data_d[8*gi + KEY_ROW + 4];
  end

  // Next-state, counters and receive datapath.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    bit_d      = bit_q;
    data_d     = data_q;
    read_d     = read_q;
    last_d     = last_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    if (accept) begin
      data_d = i_data;
      read_d = i_read;
      last_d = i_last;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          p_d     = '0;
          bit_d   = '0;
          state_d = read_q ? S_TURN : S_SHIFT_OUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT_OUT: begin
        if (p_q == P_LAST) begin
          p_d = '0;
          if (bit_q == BIT_OUT_LAST) begin
            bit_d   = '0;
            cnt_d   = '0;
            state_d = last_q ? S_GAP : S_HOLD;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          p_d = p_q + PW'(1);
        end
      end
      S_HOLD: begin
        // STB stays low between burst bytes; a new byte starts without setup.
        if (accept) begin
          p_d     = '0;
          bit_d   = '0;
          cnt_d   = '0;
          state_d = i_read ? S_TURN : S_SHIFT_OUT;
        end
      end
      S_TURN: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          p_d     = '0;
          bit_d   = '0;
          state_d = S_SHIFT_IN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT_IN: begin
        if (p_q == P_SAMPLE) begin
          rx_d = {i_dio_in, rx_q[NB-2:1]};
        end
        if ((p_q == P_SAMPLE) && (bit_q == BIT_IN_LAST)) begin
          // The final sample completes the burst; CLK is already high here.
          rd_data_d  = {i_dio_in, rx_q};
          rd_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_GAP;
        end else if (p_q == P_LAST) begin
          p_d   = '0;
          bit_d = bit_q + BW'(1);
        end else begin
          p_d = p_q + PW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin values for the next cycle, derived from the next state so pins are registered.
  always_comb begin
    clk_d = 1'b1;
    stb_d = 1'b1;
    oe_d  = 1'b0;
    dio_d = dio_q;
    unique case (state_d)
      S_IDLE, S_GAP: begin
        stb_d = 1'b1;
      end
      S_SETUP, S_TURN: begin
        stb_d = 1'b0;
      end
      S_SHIFT_OUT: begin
        stb_d = 1'b0;
        oe_d  = 1'b1;
        clk_d = (p_d >= P_HALF);
        dio_d = data_d[bit_d[2:0]];
      end
      S_HOLD: begin
        stb_d = 1'b0;
        oe_d  = 1'b1;
      end
      S_SHIFT_IN: begin
        stb_d = 1'b0;
        clk_d = (p_d >= P_HALF);
      end
      default: begin
        stb_d = 1'b1;
      end
    endcase
  end

  // State, datapath and pin registers; reset releases the pins immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      p_q        <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      read_q     <= 1'b0;
      last_q     <= 1'b0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      keys_q     <= '0;
      rd_valid_q <= 1'b0;
      clk_q      <= 1'b1;
      stb_q      <= 1'b1;
      dio_q      <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      read_q     <= read_d;
      last_q     <= last_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      keys_q     <= keys_d;
      rd_valid_q <= rd_valid_d;
      clk_q      <= clk_d;
      stb_q      <= stb_d;
      dio_q      <= dio_d;
      oe_q       <= oe_d;
    end
  end

endmodule

// File: tb/tb_tm1638_link.sv
// Scoreboard bench for tm1638_link: expected bytes/reads are queued when issued
// and popped by a pin-level monitor when the DUT shows them.
module tb_tm1638_link;

  localparam int BC = 16;
  localparam int SU = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        valid, ready, rd, last, rd_valid, sclk, stb, dio_out, dio_oe, dio_in, idle;
  logic [7:0]  data;
  logic [31:0] rd_data;
  logic [7:0]  keys;

  logic        v1_valid, v1_ready, v1_read, v1_last, v1_rd_valid;
  logic        v1_sclk, v1_stb, v1_dout, v1_oe, v1_din, v1_idle;
  logic [7:0]  v1_data, v1_rd_data;
  logic [1:0]  v1_keys;

  tm1638_link #(
    .BIT_CYCLES(BC), .STB_SETUP(SU), .WAIT_CYCLES(24), .STB_GAP(8),
    .READ_BYTES(4), .KEY_ROW(0)
  ) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
    .i_read(rd), .i_last(last), .i_data(data), .o_rd_valid(rd_valid),
    .o_rd_data(rd_data), .o_keys(keys), .o_tm1638_clk(sclk),
    .o_tm1638_stb(stb), .o_dio_out(dio_out), .o_dio_oe(dio_oe),
    .i_dio_in(dio_in), .o_idle(idle)
  );

  tm1638_link #(
    .BIT_CYCLES(BC), .STB_SETUP(SU), .WAIT_CYCLES(24), .STB_GAP(8),
    .READ_BYTES(1), .KEY_ROW(2)
  ) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1_valid), .o_ready(v1_ready),
    .i_read(v1_read), .i_last(v1_last), .i_data(v1_data), .o_rd_valid(v1_rd_valid),
    .o_rd_data(v1_rd_data), .o_keys(v1_keys), .o_tm1638_clk(v1_sclk),
    .o_tm1638_stb(v1_stb), .o_dio_out(v1_dout), .o_dio_oe(v1_oe),
    .i_dio_in(v1_din), .o_idle(v1_idle)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  keys;
  } rd_exp_t;

  logic [7:0] exp_bytes[$];
  rd_exp_t    exp_rds[$];

  int n_vec = 0;
  int n_err = 0;

  // Frame statistics gathered by the monitor.
  int low_cnt = 0, rises = 0, rd_rises = 0, oe0_run = 0, turn_len = -1;
  int last_low = 0, last_rises = 0, last_rd_rises = 0, last_turn = -1;
  int frames = 0, gap_cnt = 0, bytes_seen = 0, rdv_count = 0, v1_rd_rises = 0;
  bit in_gap = 1'b0;
  logic [31:0] resp = '0;
  logic [7:0]  resp1 = 8'h44;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Pin monitor and device model for u0, sampled on the falling system clock.
  initial begin : mon0
    logic ps, pstb;
    logic [7:0] sh;
    logic [7:0] e;
    rd_exp_t r;
    int nbits, ridx;
    ps = 1'b1; pstb = 1'b1; sh = '0; nbits = 0; ridx = 0;
    forever begin
      @(negedge clk);
      if (pstb && !stb) begin
        low_cnt = 0; rises = 0; rd_rises = 0; oe0_run = 0; turn_len = -1;
      end
      if (!stb) begin
        low_cnt++;
        if (!ps && sclk) begin
          rises++;
          if (dio_oe) begin
            sh = {dio_out, sh[7:1]};
            nbits++;
            if (nbits == 8) begin
              nbits = 0;
              bytes_seen++;
              if (exp_bytes.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_byte: got 0x%h, expected no byte", sh);
              end else begin
                e = exp_bytes.pop_front();
                chk("write_byte", 32'(sh), 32'(e));
                $display("txn write byte 0x%h", sh);
              end
            end
          end else begin
            rd_rises++;
          end
        end
        if (dio_oe) oe0_run = 0;
        else if (sclk) oe0_run++;
        if (ps && !sclk && !dio_oe) begin
          if (turn_len < 0) turn_len = oe0_run;
          dio_in = (ridx < 32) ? resp[ridx[4:0]] : 1'b0;
          ridx++;
        end
      end else begin
        nbits = 0;
        ridx  = 0;
      end
      if (rd_valid) begin
        rdv_count++;
        if (exp_rds.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_read: got 0x%h, expected no read", rd_data);
        end else begin
          r = exp_rds.pop_front();
          chk("read_data", rd_data, r.data);
          chk("read_keys", 32'(keys), 32'(r.keys));
          $display("txn read data 0x%h keys %b", rd_data, keys);
        end
      end
      if (!pstb && stb) begin
        last_low = low_cnt; last_rises = rises; last_rd_rises = rd_rises;
        last_turn = turn_len; frames++; gap_cnt = 0; in_gap = 1'b1;
      end
      if (in_gap) begin
        if (ready) in_gap = 1'b0;
        else gap_cnt++;
      end
      ps = sclk;
      pstb = stb;
    end
  end

  // Device model and pulse counter for the single-byte-read instance.
  initial begin : mon1
    logic ps1;
    int ridx1;
    ps1 = 1'b1; ridx1 = 0;
    forever begin
      @(negedge clk);
      if (v1_stb) begin
        ridx1 = 0;
      end else if (!v1_oe) begin
        if (ps1 && !v1_sclk) begin
          v1_din = resp1[ridx1[2:0]];
          ridx1++;
        end
        if (!ps1 && v1_sclk) v1_rd_rises++;
      end
      ps1 = v1_sclk;
    end
  end

  task automatic send(input logic r, input logic l, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    valid = 1'b1; rd = r; last = l; data = d;
    for (int k = 0; k < 4000; k++) begin
      if (ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    chk("accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (ready && stb) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", 32'(ok), 32'd1);
  endtask

  // Wait for the burst hold state, then stay idle there and watch the pins.
  task automatic hold_gap(input string name);
    bit ok;
    int bad;
    ok = 1'b0; bad = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("hold_reached", 32'(ok), 32'd1);
    for (int k = 0; k < 50; k++) begin
      if (!(ready && sclk && !stb)) bad++;
      @(negedge clk);
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  initial begin : main
    logic [7:0] cont [3];
    rd_exp_t rexp;
    int f0, rdv0, b0, k;
    bit ok;
    cont[0] = 8'h11; cont[1] = 8'h2C; cont[2] = 8'hE7;
    rst_n = 1'b1; valid = 1'b0; rd = 1'b0; last = 1'b0; data = '0; dio_in = 1'b0;
    v1_valid = 1'b0; v1_read = 1'b0; v1_last = 1'b0; v1_data = '0; v1_din = 1'b0;

    // Asynchronous reset, checked before the first clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("reset_clk", 32'(sclk), 32'd1);
    chk("reset_stb", 32'(stb), 32'd1);
    chk("reset_oe", 32'(dio_oe), 32'd0);
    chk("reset_dio", 32'(dio_out), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_keys", 32'(keys), 32'd0);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_idle", 32'(idle), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single write 0xA5 with last.
    exp_bytes.push_back(8'hA5);
    send(1'b0, 1'b1, 8'hA5);
    wait_idle();
    chk("a5_stb_low", 32'(last_low), 32'd132);
    chk("a5_ready_gap", 32'(gap_cnt), 32'd8);
    chk("a5_rises", 32'(last_rises), 32'd8);

    // Burst of three bytes under one STB with idle gaps.
    f0 = frames;
    exp_bytes.push_back(8'hC0);
    send(1'b0, 1'b0, 8'hC0);
    hold_gap("burst_gap1");
    exp_bytes.push_back(8'h3F);
    send(1'b0, 1'b0, 8'h3F);
    hold_gap("burst_gap2");
    exp_bytes.push_back(8'h06);
    send(1'b0, 1'b1, 8'h06);
    wait_idle();
    chk("burst_frames", 32'(frames - f0), 32'd1);
    chk("burst_rises", 32'(last_rises), 32'd24);

    // Command byte then 4-byte read. Bytes 01,10,00,11:
    // keys[3:0] = bit0 of bytes 3..0 = 1,0,0,1; keys[7:4] = bit4 of bytes 3..0 = 1,0,1,0.
    resp = 32'h1100_1001;
    rdv0 = rdv_count;
    exp_bytes.push_back(8'h42);
    rexp.data = 32'h1100_1001;
    rexp.keys = 8'b1010_1001;
    exp_rds.push_back(rexp);
    send(1'b0, 1'b0, 8'h42);
    send(1'b1, 1'b0, 8'h00);
    wait_idle();
    chk("read_turnaround", 32'(last_turn), 32'd24);
    chk("read_pulses", 32'(last_rd_rises), 32'd32);
    chk("read_frame_rises", 32'(last_rises), 32'd40);
    chk("read_valid_pulses", 32'(rdv_count - rdv0), 32'd1);
    chk("read_popped", 32'(exp_rds.size()), 32'd0);

    // i_valid held high across three single-byte frames.
    b0 = bytes_seen;
    for (int i = 0; i < 3; i++) exp_bytes.push_back(cont[i]);
    @(negedge clk);
    valid = 1'b1; rd = 1'b0; last = 1'b1; data = cont[0]; k = 0;
    for (int t = 0; t < 3000 && k < 3; t++) begin
      if (ready) begin
        @(posedge clk);
        #1;
        k++;
        if (k < 3) data = cont[k];
        else valid = 1'b0;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    chk("cont_accepts", 32'(k), 32'd3);
    wait_idle();
    chk("cont_bytes", 32'(bytes_seen - b0), 32'd3);
    chk("cont_queue_empty", 32'(exp_bytes.size()), 32'd0);

    // Reset in the middle of bit 3 of a write.
    exp_bytes.push_back(8'h5A);
    send(1'b0, 1'b1, 8'h5A);
    repeat (SU + 3*BC + 4) @(negedge clk);
    chk("pre_reset_clk_low", 32'(sclk), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_stb", 32'(stb), 32'd1);
    chk("midrst_clk", 32'(sclk), 32'd1);
    chk("midrst_oe", 32'(dio_oe), 32'd0);
    chk("midrst_rd_data", rd_data, 32'd0);
    exp_bytes.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", 32'(ready), 32'd1);
    exp_bytes.push_back(8'h81);
    send(1'b0, 1'b1, 8'h81);
    wait_idle();
    chk("postrst_queue_empty", 32'(exp_bytes.size()), 32'd0);

    // Single-byte read on the READ_BYTES=1, KEY_ROW=2 instance, byte 0x44.
    v1_rd_rises = 0;
    @(negedge clk);
    v1_valid = 1'b1; v1_read = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (v1_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    v1_valid = 1'b0;
    chk("u1_accept", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (v1_rd_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("u1_rd_valid", 32'(ok), 32'd1);
    chk("u1_rd_data", 32'(v1_rd_data), 32'h44);
    chk("u1_keys", 32'(v1_keys), 32'd3);
    $display("txn u1 read data 0x%h keys %b", v1_rd_data, v1_keys);
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (v1_ready && v1_stb) begin
        ok = 1'b1;
        break;
      end
    end
    chk("u1_idle_reached", 32'(ok), 32'd1);
    chk("u1_pulses", 32'(v1_rd_rises), 32'd8);
    chk("u1_idle", 32'(v1_idle), 32'd1);
    chk("u1_dio_out", 32'(v1_dout), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
